// File: rtl/doodle_motion.sv
// doodle_motion: frame-paced motion generator for the doodle sprite.
// Tracks the horizontal/vertical position and the current jump height
// from the one-hot game state, stepping once every TICK_DIV clocks.
module doodle_motion #(
    parameter int TICK_DIV = 500000,
    parameter int X_INIT   = 459,
    parameter int Y_INIT   = 480,
    parameter int X_MIN    = 144,
    parameter int X_MAX    = 774,
    parameter int Y_TOP    = 35,
    parameter int H_STEP   = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        q_I,
    input  logic        q_Up,
    input  logic        q_Down,
    input  logic        q_Done,
    input  logic        is_in_middle,
    input  logic [3:0]  vert_speed,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [9:0]  up_count,
    output logic [15:0] object_x,
    output logic [15:0] object_y,
    output logic        step,
    output logic        state_err
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [15:0]   X_INIT16   = 16'(X_INIT);
    localparam logic [15:0]   Y_INIT16   = 16'(Y_INIT);
    localparam logic [15:0]   X_MIN16    = 16'(X_MIN);
    localparam logic [15:0]   X_MAX16    = 16'(X_MAX);
    localparam logic [15:0]   Y_TOP16    = 16'(Y_TOP);
    localparam logic [16:0]   X_MAX17    = 17'(X_MAX);
    localparam logic [16:0]   H_STEP17   = 17'(H_STEP);
    localparam logic [16:0]   X_LEFT_LIM = 17'(X_MIN + H_STEP);
    localparam logic [16:0]   Y_TOP17    = 17'(Y_TOP);

    logic [CW-1:0] r_tick;
    logic [CW-1:0] w_tick_next;
    logic          r_step;
    logic          r_q_up_d;
    logic          r_state_err;
    logic [9:0]    r_up_count;
    logic [15:0]   r_x;
    logic [15:0]   r_y;

    logic [3:0]    w_state;
    logic          w_onehot;
    logic          w_rise;
    logic [10:0]   w_up_sum;
    logic [9:0]    w_up_sat;
    logic [16:0]   w_x_ext;
    logic [16:0]   w_y_ext;
    logic [16:0]   w_vs_ext;
    logic [16:0]   w_y_down_sum;
    logic [15:0]   w_y_down;
    logic [15:0]   w_y_up;
    logic [15:0]   w_x_next;

    assign w_tick_next = (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;

    // Zero bits or two-plus bits set both count as an illegal state.
    assign w_state  = {q_I, q_Up, q_Down, q_Done};
    assign w_onehot = (w_state != 4'd0) && ((w_state & (w_state - 4'd1)) == 4'd0);
    assign w_rise   = q_Up & ~r_q_up_d;

    // Widened arithmetic so saturation/clamp tests see the carry/borrow.
    assign w_vs_ext     = {13'd0, vert_speed};
    assign w_x_ext      = {1'b0, r_x};
    assign w_y_ext      = {1'b0, r_y};
    assign w_up_sum     = {1'b0, r_up_count} + {7'd0, vert_speed};
    assign w_up_sat     = w_up_sum[10] ? 10'd1023 : w_up_sum[9:0];
    assign w_y_down_sum = w_y_ext + w_vs_ext;
    assign w_y_down     = w_y_down_sum[16] ? 16'hFFFF : w_y_down_sum[15:0];
    // max(y - speed, Y_TOP) without ever forming a negative value.
    assign w_y_up       = (w_y_ext < (w_vs_ext + Y_TOP17)) ? Y_TOP16 : (r_y - {12'd0, vert_speed});

    // Horizontal wrap-around: leaving one edge re-enters at the other.
    always_comb begin
        w_x_next = r_x;
        if (btn_left && !btn_right) begin
            if (w_x_ext < X_LEFT_LIM) begin
                w_x_next = X_MAX16;
            end else begin
                w_x_next = r_x - H_STEP17[15:0];
            end
        end else if (btn_right && !btn_left) begin
            if ((w_x_ext + H_STEP17) > X_MAX17) begin
                w_x_next = X_MIN16;
            end else begin
                w_x_next = r_x + H_STEP17[15:0];
            end
        end
    end

    // Frame tick: free-running divider with a registered one-cycle step pulse.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tick <= '0;
            r_step <= 1'b0;
        end else begin
            r_tick <= w_tick_next;
            r_step <= (w_tick_next == TICK_LAST);
        end
    end

    // Per-cycle monitors: q_Up edge history and sticky illegal-state flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_q_up_d    <= 1'b0;
            r_state_err <= 1'b0;
        end else begin
            r_q_up_d <= q_Up;
            if (!w_onehot) begin
                r_state_err <= 1'b1;
            end
        end
    end

    // Position and jump-height update, frozen while the state is illegal.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_x        <= X_INIT16;
            r_y        <= Y_INIT16;
            r_up_count <= 10'd0;
        end else if (w_onehot) begin
            if (r_step) begin
                if (q_I) begin
                    r_x        <= X_INIT16;
                    r_y        <= Y_INIT16;
                    r_up_count <= 10'd0;
                end else if (q_Up) begin
                    r_up_count <= w_up_sat;
                    if (!is_in_middle) begin
                        r_y <= w_y_up;
                    end
                    r_x <= w_x_next;
                end else if (q_Down) begin
                    r_up_count <= 10'd0;
                    r_y        <= w_y_down;
                    r_x        <= w_x_next;
                end
            end
            // A fresh rise (start or bounce) restarts the jump; this
            // overrides any increment made by a coincident step.
            if (w_rise) begin
                r_up_count <= 10'd0;
            end
        end
    end

    assign up_count  = r_up_count;
    assign object_x  = r_x;
    assign object_y  = r_y;
    assign step      = r_step;
    assign state_err = r_state_err;

endmodule

// File: tb/tb_doodle_motion.sv
// tb_doodle_motion: directed, table-driven checks of doodle_motion with TICK_DIV=4.
module tb_doodle_motion;

    localparam logic [3:0] ST_I    = 4'b1000;
    localparam logic [3:0] ST_UP   = 4'b0100;
    localparam logic [3:0] ST_DN   = 4'b0010;
    localparam logic [3:0] ST_DONE = 4'b0001;

    logic        Clk;
    logic        Reset;
    logic        q_I, q_Up, q_Down, q_Done;
    logic        is_in_middle;
    logic [3:0]  vert_speed;
    logic        btn_left, btn_right;
    logic [9:0]  up_count;
    logic [15:0] object_x, object_y;
    logic        step;
    logic        state_err;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [3:0] st;
        logic       mid;
        logic [3:0] vs;
        logic       bl;
        logic       br;
        int         ex;
        int         ey;
        int         eup;
    } vec_t;

    vec_t vecs [14];

    doodle_motion #(.TICK_DIV(4)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .q_I          (q_I),
        .q_Up         (q_Up),
        .q_Down       (q_Down),
        .q_Done       (q_Done),
        .is_in_middle (is_in_middle),
        .vert_speed   (vert_speed),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .up_count     (up_count),
        .object_x     (object_x),
        .object_y     (object_y),
        .step         (step),
        .state_err    (state_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] st, input logic mid, input logic [3:0] vs,
                          input logic bl, input logic br);
        {q_I, q_Up, q_Down, q_Done} = st;
        is_in_middle = mid;
        vert_speed   = vs;
        btn_left     = bl;
        btn_right    = br;
    endtask

    // Stops at the negedge where step is visible; bounded.
    task automatic wait_step();
        bit seen = 1'b0;
        for (int n = 0; n < 16; n++) begin
            @(negedge Clk);
            if (step) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_err++;
            $display("FAIL step_timeout: got no step expected step within 16 cycles");
        end
    endtask

    // Let one step apply, then sit at the following negedge.
    task automatic do_step();
        wait_step();
        @(negedge Clk);
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey, input int eup);
        chk({tag, " x"}, int'(object_x), ex);
        chk({tag, " y"}, int'(object_y), ey);
        chk({tag, " up"}, int'(up_count), eup);
    endtask

    task automatic check_step_pattern(input string tag);
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            chk($sformatf("%s step_cyc%0d", tag, k), int'(step), (k % 4 == 3) ? 1 : 0);
        end
    endtask

    initial begin
        vecs[0]  = '{ST_I,    1'b0, 4'd5, 1'b0, 1'b0, 459, 480, 0};
        vecs[1]  = '{ST_UP,   1'b0, 4'd5, 1'b0, 1'b0, 459, 475, 5};
        vecs[2]  = '{ST_UP,   1'b0, 4'd5, 1'b0, 1'b0, 459, 470, 10};
        vecs[3]  = '{ST_UP,   1'b0, 4'd5, 1'b0, 1'b0, 459, 465, 15};
        vecs[4]  = '{ST_UP,   1'b1, 4'd5, 1'b0, 1'b0, 459, 465, 20};
        vecs[5]  = '{ST_UP,   1'b1, 4'd5, 1'b0, 1'b0, 459, 465, 25};
        vecs[6]  = '{ST_DN,   1'b1, 4'd4, 1'b0, 1'b0, 459, 469, 0};
        vecs[7]  = '{ST_DN,   1'b0, 4'd4, 1'b0, 1'b0, 459, 473, 0};
        vecs[8]  = '{ST_UP,   1'b0, 4'd4, 1'b1, 1'b0, 456, 469, 4};
        vecs[9]  = '{ST_UP,   1'b0, 4'd4, 1'b1, 1'b1, 456, 465, 8};
        vecs[10] = '{ST_UP,   1'b0, 4'd4, 1'b0, 1'b1, 459, 461, 12};
        vecs[11] = '{ST_UP,   1'b0, 4'd4, 1'b0, 1'b1, 462, 457, 16};
        vecs[12] = '{ST_DONE, 1'b0, 4'd9, 1'b1, 1'b0, 462, 457, 16};
        vecs[13] = '{ST_DONE, 1'b0, 4'd9, 1'b0, 1'b1, 462, 457, 16};

        // Reset and idle
        Reset = 1'b1;
        set_in(ST_I, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) @(negedge Clk);
        chk_pos("reset", 459, 480, 0);
        chk("reset step", int'(step), 0);
        chk("reset err", int'(state_err), 0);
        Reset = 1'b0;
        check_step_pattern("idle");

        // Table-driven single steps
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].st, vecs[i].mid, vecs[i].vs, vecs[i].bl, vecs[i].br);
            do_step();
            chk_pos($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].eup);
            $display("vec %0d: st=%b x=%0d y=%0d up=%0d", i, vecs[i].st, object_x, object_y, up_count);
        end

        // Rise coincident with step: clear wins, y still moves
        wait_step();
        set_in(ST_UP, 1'b0, 4'd3, 1'b0, 1'b0);
        @(negedge Clk);
        chk_pos("rise_on_step", 462, 454, 0);
        $display("rise_on_step: x=%0d y=%0d up=%0d", object_x, object_y, up_count);

        // Off-step bounce clears up_count the next cycle
        do_step();
        chk_pos("rise_prep", 462, 451, 3);
        set_in(ST_DONE, 1'b0, 4'd3, 1'b0, 1'b0);
        @(negedge Clk);
        set_in(ST_UP, 1'b0, 4'd3, 1'b0, 1'b0);
        @(negedge Clk);
        chk("rise_off_step up", int'(up_count), 0);
        $display("rise_off_step: up=%0d", up_count);

        // Zero speed fall: no vertical motion
        set_in(ST_DN, 1'b0, 4'd0, 1'b0, 1'b0);
        do_step();
        chk_pos("fall_vs0", 462, 451, 0);
        $display("fall_vs0: y=%0d", object_y);

        // up_count saturation
        set_in(ST_UP, 1'b1, 4'd15, 1'b0, 1'b0);
        for (int n = 0; n < 68; n++) do_step();
        chk_pos("up_1020", 462, 451, 1020);
        vert_speed = 4'd7;
        do_step();
        chk_pos("up_sat", 462, 451, 1023);
        $display("up_sat: up=%0d", up_count);

        // Top clamp
        set_in(ST_UP, 1'b0, 4'd15, 1'b0, 1'b0);
        for (int n = 0; n < 27; n++) do_step();
        vert_speed = 4'd9;
        do_step();
        chk("y_37", int'(object_y), 37);
        vert_speed = 4'd5;
        do_step();
        chk("y_clamp", int'(object_y), 35);
        do_step();
        chk_pos("y_clamp_hold", 462, 35, 1023);
        $display("y_clamp: y=%0d", object_y);

        // Horizontal boundaries and wrap
        set_in(ST_UP, 1'b1, 4'd0, 1'b1, 1'b0);
        for (int n = 0; n < 105; n++) do_step();
        chk("x_147", int'(object_x), 147);
        do_step();
        chk("x_left_edge", int'(object_x), 144);
        do_step();
        chk("x_left_wrap", int'(object_x), 774);
        set_in(ST_UP, 1'b1, 4'd0, 1'b0, 1'b1);
        do_step();
        chk("x_right_wrap", int'(object_x), 144);
        for (int n = 0; n < 209; n++) do_step();
        chk("x_771", int'(object_x), 771);
        do_step();
        chk("x_right_edge", int'(object_x), 774);
        $display("wrap: x=%0d", object_x);

        // Illegal state: sticky error, everything holds
        set_in(ST_UP | ST_DN, 1'b0, 4'd5, 1'b1, 1'b0);
        @(negedge Clk);
        chk("err_set", int'(state_err), 1);
        do_step();
        chk_pos("err_hold", 774, 35, 1023);
        set_in(ST_UP, 1'b0, 4'd5, 1'b0, 1'b0);
        @(negedge Clk);
        chk("err_sticky", int'(state_err), 1);
        $display("err: state_err=%0d x=%0d", state_err, object_x);

        // Asynchronous reset in the middle of a count
        set_in(ST_I, 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk_pos("async_rst", 459, 480, 0);
        chk("async_rst step", int'(step), 0);
        chk("async_rst err", int'(state_err), 0);
        @(negedge Clk);
        Reset = 1'b0;
        check_step_pattern("post_rst");
        $display("async_rst: x=%0d y=%0d up=%0d err=%0d", object_x, object_y, up_count, state_err);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
